inst_fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle RV64 core. It sits directly upstream of the decoder/execute datapath.

- Owns the architectural PC register.
- Issues one request at a time to instruction memory over a valid/ready request channel plus a response channel.
- Presents each fetched instruction and its PC to decode with a valid/ready handshake.
- Accepts PC redirects from execute for jumps, branches and exceptions, and discards any fetch already in flight.

---
 rtl/inst_fetch_unit.sv | 137 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and hands instructions to decode.
// Optional IFU_MISALIGN_CHECK_EN turns a misaligned PC into a local fetch fault without touching memory.
module inst_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    discard_q, discard_d;
  logic                    req_valid_q, req_valid_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [INST_WIDTH-1:0]   inst_q, inst_d;
  logic [ADDR_WIDTH-1:0]   inst_pc_q, inst_pc_d;
  logic                    inst_fault_q, inst_fault_d;
  logic                    misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    // NOTE: every *_d gets a hold-value default first so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect_valid) pc_d = redirect_target;
        if (misaligned) begin
          if (!redirect_valid) begin
            state_d      = HOLD;
            inst_d       = '0;
            inst_pc_d    = pc_q;
            inst_fault_d = 1'b1;
          end
        end else if (imem_req_ready) begin
          // The old-pc request is already accepted; its response must be dropped.
          state_d   = WAIT;
          discard_d = redirect_valid;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d      = redirect_target;
          discard_d = !imem_resp_valid;
          if (imem_resp_valid) state_d = REQ;
        end else if (imem_resp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            inst_d       = imem_resp_data;
            inst_pc_d    = pc_q;
            inst_fault_d = imem_resp_err;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    inst_valid_d = (state_d == HOLD);
`ifdef IFU_MISALIGN_CHECK_EN
    req_valid_d  = (state_d == REQ) && (pc_d[1:0] == 2'b00);
`else
    req_valid_d  = (state_d == REQ);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = inst_fault_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; memory and decode are driven step by step with hand-computed expectations.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_fault      (inst_fault)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_valid  = 1'b1;
    redirect_target = target;
    tick();
    redirect_valid  = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_resp_err = 1'b0; inst_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_fault", inst_fault, 0);
    check("rst_addr", imem_req_addr, 64'h8000_0000);

    // Reset fetch: REQ one cycle after release, inst_valid two cycles later
    rst = 1'b0;
    tick();
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 64'h8000_0000);
    tick();
    check("wait_req_valid", imem_req_valid, 0);
    respond(32'h0010_0093, 1'b0);
    check("first_inst_valid", inst_valid, 1);
    check("first_inst", inst, 32'h0010_0093);
    check("first_inst_pc", inst_pc, 64'h8000_0000);
    check("first_fault", inst_fault, 0);

    // Backpressure: held stable for 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_valid", inst_valid, 1);
      check("bp_inst", inst, 32'h0010_0093);
      check("bp_pc", inst_pc, 64'h8000_0000);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("seq_inst_valid", inst_valid, 0);
    check("seq_req_addr", imem_req_addr, 64'h8000_0004);
    check("seq_req_valid", imem_req_valid, 1);

    // Redirect in WAIT: pending response dropped
    tick();
    redirect(64'h8000_0100);
    respond(32'hDEAD_BEEF, 1'b0);
    check("rw_dropped", inst_valid, 0);
    check("rw_req_valid", imem_req_valid, 1);
    check("rw_req_addr", imem_req_addr, 64'h8000_0100);
    tick();
    respond(32'h0020_0113, 1'b0);
    check("rw_inst_valid", inst_valid, 1);
    check("rw_inst_pc", inst_pc, 64'h8000_0100);
    check("rw_inst", inst, 32'h0020_0113);

    // Redirect in HOLD with inst_ready=1 the same cycle
    inst_ready = 1'b1;
    redirect(64'h8000_0200);
    inst_ready = 1'b0;
    check("rh_inst_valid", inst_valid, 0);
    check("rh_req_addr", imem_req_addr, 64'h8000_0200);

    // Access fault passes data through
    tick();
    respond(32'h1234_5678, 1'b1);
    check("flt_valid", inst_valid, 1);
    check("flt_fault", inst_fault, 1);
    check("flt_inst", inst, 32'h1234_5678);
    check("flt_pc", inst_pc, 64'h8000_0200);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("flt_next_addr", imem_req_addr, 64'h8000_0204);

    // Redirect in REQ without handshake: new pc used for the request
    imem_req_ready = 1'b0;
    redirect(64'h8000_0300);
    check("rq_req_valid", imem_req_valid, 1);
    check("rq_req_addr", imem_req_addr, 64'h8000_0300);

    // Redirect in REQ with handshake: old request accepted, its response discarded
    imem_req_ready = 1'b1;
    redirect(64'h8000_0400);
    check("rqa_in_wait", imem_req_valid, 0);
    respond(32'hBAD0_BAD0, 1'b0);
    check("rqa_dropped", inst_valid, 0);
    check("rqa_req_addr", imem_req_addr, 64'h8000_0400);

    // Misaligned target
    imem_req_ready = 1'b0;
    redirect(64'h8000_0102);
    check("mis_req_addr", imem_req_addr, 64'h8000_0102);
`ifdef IFU_MISALIGN_CHECK_EN
    check("mis_no_req", imem_req_valid, 0);
    tick();
    check("mis_valid", inst_valid, 1);
    check("mis_fault", inst_fault, 1);
    check("mis_inst", inst, 0);
    check("mis_pc", inst_pc, 64'h8000_0102);
`else
    check("mis_req", imem_req_valid, 1);
    imem_req_ready = 1'b1;
    tick();
    respond(32'h0000_0073, 1'b1);
    check("mis_valid", inst_valid, 1);
    check("mis_fault", inst_fault, 1);
    check("mis_pc", inst_pc, 64'h8000_0102);
`endif
    imem_req_ready = 1'b1;
    redirect(64'h8000_0500);
    check("mis_exit_valid", inst_valid, 0);
    check("mis_exit_addr", imem_req_addr, 64'h8000_0500);

    // Reset mid-WAIT, stale response and IDLE redirect ignored
    tick();
    rst = 1'b1;
    tick();
    check("rmw_req_valid", imem_req_valid, 0);
    check("rmw_addr", imem_req_addr, 64'h8000_0000);
    check("rmw_inst_valid", inst_valid, 0);
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hFFFF_FFFF;
    redirect(64'h9000_0000);
    check("rmw_stale_ignored", inst_valid, 0);
    check("rmw_req_addr", imem_req_addr, 64'h8000_0000);
    check("rmw_req_valid2", imem_req_valid, 1);
    imem_resp_valid = 1'b0;
    tick();
    respond(32'h0030_0193, 1'b0);
    check("rmw_inst", inst, 32'h0030_0193);
    check("rmw_inst_pc", inst_pc, 64'h8000_0000);

    // PC wraps modulo 2^64
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    respond(32'h0000_0013, 1'b0);
    check("wrap_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("wrap_addr", imem_req_addr, 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
